// File: rtl/audio_mix_pkg.sv
// Shared widths, ramp constants and the soft-mute state type for the audio mixer.
package audio_mix_pkg;

  localparam int SAMPLE_W = 14;
  localparam int OUT_W    = 16;
  localparam int SUM_W    = 18;
  localparam int GAIN_W   = 19;
  localparam int LEVEL_W  = 7;

  localparam logic [LEVEL_W-1:0] RAMP_MAX   = 7'd64;
  localparam logic [3:0]         UNITY_GAIN = 4'd8;

  typedef enum logic [1:0] {
    MUTED,
    RAMP_UP,
    ACTIVE,
    RAMP_DOWN
  } mute_state_t;

  function automatic logic signed [SUM_W-1:0] widen(input logic signed [SAMPLE_W-1:0] x);
    return {{(SUM_W-SAMPLE_W){x[SAMPLE_W-1]}}, x};
  endfunction

endpackage

// File: rtl/audio_mix_sat.sv
// Applies the soft-mute level to one gained channel and saturates it to the output width.
module audio_mix_sat
  import audio_mix_pkg::*;
(
  input  logic signed [GAIN_W-1:0]  gain_i,
  input  logic        [LEVEL_W-1:0] level_i,
  output logic signed [OUT_W-1:0]   sample_o,
  output logic                      clip_o
);

  localparam int PROD_W = GAIN_W + LEVEL_W + 1;
  localparam int M_W    = PROD_W - 6;
  localparam logic signed [M_W-1:0] M_HI = M_W'(32767);
  localparam logic signed [M_W-1:0] M_LO = M_W'(-32768);

  logic signed [PROD_W-1:0] prod;
  logic signed [M_W-1:0]    m;

  always_comb begin
    prod     = PROD_W'(gain_i) * PROD_W'($signed({1'b0, level_i}));
    // dropping the low six bits of a signed product is a floor divide by 64
    m        = prod[PROD_W-1:6];
    clip_o   = 1'b0;
    sample_o = m[OUT_W-1:0];
    if (m > M_HI) begin
      sample_o = 16'sh7FFF;
      clip_o   = 1'b1;
    end else if (m < M_LO) begin
      sample_o = 16'sh8000;
      clip_o   = 1'b1;
    end
  end

endmodule

// File: rtl/audio_mix.sv
// Three-stage stereo mixer with master gain, soft-mute ramp and clip counter.
// Optional DC blocker between sum and gain stages: define AUDIO_MIX_DC_BLOCK_EN.
//
// state     | meaning
// MUTED     | level 0, output silent
// RAMP_UP   | level stepping toward 64, one step per strobe
// ACTIVE    | level 64, full gain
// RAMP_DOWN | level stepping toward 0, one step per strobe
module audio_mix
  import audio_mix_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_stb_i,
  input  logic signed [SAMPLE_W-1:0] ssp_i,
  input  logic signed [SAMPLE_W-1:0] mb_l_i,
  input  logic signed [SAMPLE_W-1:0] mb_r_i,
  input  logic signed [SAMPLE_W-1:0] spk_i,
  input  logic        [3:0]          volume_i,
  input  logic                       mute_i,
  input  logic                       clr_clip_i,
  output logic signed [OUT_W-1:0]    core_l_o,
  output logic signed [OUT_W-1:0]    core_r_o,
  output logic                       valid_o,
  output logic        [7:0]          clip_count_o
);

  localparam int PV_W = SUM_W + 5;

  mute_state_t              state_q;
  logic [LEVEL_W-1:0]       level_q;
  logic                     s1_valid, s2_valid;
  logic signed [SUM_W-1:0]  sum_l, sum_r;
  logic [LEVEL_W-1:0]       level_s1, level_s2;
  logic signed [SUM_W-1:0]  pre_l, pre_r;
  logic [LEVEL_W-1:0]       pre_level;
  logic                     pre_valid;
  logic signed [PV_W-1:0]   prod_l, prod_r;
  logic signed [GAIN_W-1:0] g_l, g_r;
  logic signed [OUT_W-1:0]  sat_l, sat_r;
  logic                     clip_l, clip_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MUTED;
      level_q <= '0;
    end else if (sample_stb_i) begin
      if (mute_i) begin
        if (level_q != '0) level_q <= level_q - LEVEL_W'(1);
        state_q <= (level_q <= LEVEL_W'(1)) ? MUTED : RAMP_DOWN;
      end else begin
        if (level_q != RAMP_MAX) level_q <= level_q + LEVEL_W'(1);
        state_q <= (level_q >= RAMP_MAX - LEVEL_W'(1)) ? ACTIVE : RAMP_UP;
      end
    end
  end

  // The sample rides with the level in force before this strobe's ramp step.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      sum_l    <= '0;
      sum_r    <= '0;
      level_s1 <= '0;
    end else begin
      s1_valid <= sample_stb_i;
      if (sample_stb_i) begin
        sum_l    <= widen(ssp_i) + widen(mb_l_i) + widen(spk_i);
        sum_r    <= widen(ssp_i) + widen(mb_r_i) + widen(spk_i);
        level_s1 <= level_q;
      end
    end
  end

`ifdef AUDIO_MIX_DC_BLOCK_EN
  localparam int DC_W   = 20;
  localparam int DC_A_W = DC_W + 1;

  logic signed [SUM_W-1:0]  xp_l, xp_r, dc_l, dc_r;
  logic signed [DC_W-1:0]   yp_l, yp_r;
  logic signed [DC_A_W-1:0] yn_l, yn_r;
  logic                     dc_valid;
  logic [LEVEL_W-1:0]       level_dc;

  function automatic logic signed [DC_W-1:0] clamp_state(input logic signed [DC_A_W-1:0] x);
    if (x > 21'sd524287)       return 20'sd524287;
    else if (x < -21'sd524288) return -20'sd524288;
    else                       return x[DC_W-1:0];
  endfunction

  function automatic logic signed [SUM_W-1:0] clamp_sum(input logic signed [DC_A_W-1:0] x);
    if (x > 21'sd131071)       return 18'sd131071;
    else if (x < -21'sd131072) return -18'sd131072;
    else                       return x[SUM_W-1:0];
  endfunction

  always_comb begin
    yn_l = DC_A_W'(sum_l) - DC_A_W'(xp_l) + DC_A_W'(yp_l) - DC_A_W'(yp_l >>> 10);
    yn_r = DC_A_W'(sum_r) - DC_A_W'(xp_r) + DC_A_W'(yp_r) - DC_A_W'(yp_r >>> 10);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dc_valid <= 1'b0;
      xp_l     <= '0;
      xp_r     <= '0;
      yp_l     <= '0;
      yp_r     <= '0;
      dc_l     <= '0;
      dc_r     <= '0;
      level_dc <= '0;
    end else begin
      dc_valid <= s1_valid;
      if (s1_valid) begin
        xp_l     <= sum_l;
        xp_r     <= sum_r;
        yp_l     <= clamp_state(yn_l);
        yp_r     <= clamp_state(yn_r);
        dc_l     <= clamp_sum(yn_l);
        dc_r     <= clamp_sum(yn_r);
        level_dc <= level_s1;
      end
    end
  end

  assign pre_l     = dc_l;
  assign pre_r     = dc_r;
  assign pre_level = level_dc;
  assign pre_valid = dc_valid;
`else
  assign pre_l     = sum_l;
  assign pre_r     = sum_r;
  assign pre_level = level_s1;
  assign pre_valid = s1_valid;
`endif

  always_comb begin
    prod_l = PV_W'(pre_l) * PV_W'($signed({1'b0, volume_i}));
    prod_r = PV_W'(pre_r) * PV_W'($signed({1'b0, volume_i}));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      g_l      <= '0;
      g_r      <= '0;
      level_s2 <= '0;
    end else begin
      s2_valid <= pre_valid;
      if (pre_valid) begin
        // |sum*15/8| stays below 2^16, so the 19-bit slice never truncates
        g_l      <= prod_l[GAIN_W+2:3];
        g_r      <= prod_r[GAIN_W+2:3];
        level_s2 <= pre_level;
      end
    end
  end

  audio_mix_sat u_sat_l (
    .gain_i   (g_l),
    .level_i  (level_s2),
    .sample_o (sat_l),
    .clip_o   (clip_l)
  );

  audio_mix_sat u_sat_r (
    .gain_i   (g_r),
    .level_i  (level_s2),
    .sample_o (sat_r),
    .clip_o   (clip_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_o      <= 1'b0;
      core_l_o     <= '0;
      core_r_o     <= '0;
      clip_count_o <= '0;
    end else begin
      valid_o <= s2_valid;
      if (s2_valid) begin
        core_l_o <= sat_l;
        core_r_o <= sat_r;
      end
      if (clr_clip_i)
        clip_count_o <= '0;
      else if (s2_valid && (clip_l || clip_r) && clip_count_o != 8'hFF)
        clip_count_o <= clip_count_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_audio_mix.sv
// Scoreboard bench for audio_mix: arithmetic reference model, directed scenarios, random traffic.
module tb_audio_mix;
  import audio_mix_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_stb_i = 1'b0;
  logic mute_i = 1'b0;
  logic clr_clip_i = 1'b0;
  logic signed [13:0] ssp_i = '0, mb_l_i = '0, mb_r_i = '0, spk_i = '0;
  logic [3:0] volume_i = 4'd8;
  logic signed [15:0] core_l_o, core_r_o;
  logic valid_o;
  logic [7:0] clip_count_o;

  audio_mix dut (
    .clk          (clk),
    .reset        (reset),
    .sample_stb_i (sample_stb_i),
    .ssp_i        (ssp_i),
    .mb_l_i       (mb_l_i),
    .mb_r_i       (mb_r_i),
    .spk_i        (spk_i),
    .volume_i     (volume_i),
    .mute_i       (mute_i),
    .clr_clip_i   (clr_clip_i),
    .core_l_o     (core_l_o),
    .core_r_o     (core_r_o),
    .valid_o      (valid_o),
    .clip_count_o (clip_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int l;
    int r;
    bit clip;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int errors = 0, checks = 0, cyc = 0, lvl = 0, nvalid = 0;
  int last_l = 0, last_r = 0, exp_cnt = 0;
  bit rst_q = 0, clr_q = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic int fdiv(input int a, input int b);
    int q = a / b;
    if ((a % b) != 0 && a < 0) q--;
    return q;
  endfunction

  // reference: floor(floor(sum*vol/8)*level/64), clamped to 16-bit signed
  function automatic int mix(input int sum, input int vol, input int level, output bit clip);
    int m;
    m = fdiv(fdiv(sum * vol, 8) * level, 64);
    clip = 1'b0;
    if (m > 32767) begin m = 32767; clip = 1'b1; end
    else if (m < -32768) begin m = -32768; clip = 1'b1; end
    return m;
  endfunction

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
    clr_q <= clr_clip_i;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_q) begin
      exp_cnt = 0;
    end else begin
      if (clr_q) exp_cnt = 0;
      if (valid_o) begin
        nvalid++;
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("core_l", int'(core_l_o), e.l);
          chk("core_r", int'(core_r_o), e.r);
          chk("latency", cyc - e.cyc, 3);
          if (e.clip && !clr_q && exp_cnt != 255) exp_cnt++;
          last_l = core_l_o;
          last_r = core_r_o;
        end
        chk("clip_count", int'(clip_count_o), exp_cnt);
      end
    end
  end

  task automatic strobe(input int a, input int b, input int c, input int d);
    exp_t e;
    bit cl, cr;
    ssp_i = 14'(a); mb_l_i = 14'(b); mb_r_i = 14'(c); spk_i = 14'(d);
    sample_stb_i = 1'b1;
    e.l = mix(a + b + d, int'(volume_i), lvl, cl);
    e.r = mix(a + c + d, int'(volume_i), lvl, cr);
    e.clip = cl | cr;
    e.cyc = cyc;
    sb.push_back(e);
    if (mute_i) lvl = (lvl > 0) ? lvl - 1 : 0;
    else        lvl = (lvl < 64) ? lvl + 1 : 64;
    @(posedge clk); #1;
    sample_stb_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && sb.size() != 0; n++) begin @(posedge clk); #1; end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    idle(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    lvl = 0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  initial begin
    int nv;
    idle(3);
    do_reset();
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_core_l", int'(core_l_o), 0);
    chk("rst_core_r", int'(core_r_o), 0);
    chk("rst_clip_count", int'(clip_count_o), 0);
    chk("rst_level", int'(dut.level_q), 0);
    chk("rst_state", int'(dut.state_q), int'(MUTED));

    // ramp-up from reset at unity gain
    volume_i = UNITY_GAIN;
    mute_i = 1'b0;
    for (int n = 0; n < 65; n++) begin strobe(6400, 0, 0, 0); idle(9); end
    drain();
    chk("ramp_last", last_l, 6400);
    chk("ramp_state", int'(dut.state_q), int'(ACTIVE));

    // unity mix
    strobe(1000, 2000, -500, 0);
    drain();
    chk("unity_l", last_l, 3000);
    chk("unity_r", last_r, 500);
    chk("unity_clip", int'(clip_count_o), 0);

    // saturation, one count per event
    volume_i = 4'd15;
    strobe(8191, 8191, 8191, 8191);
    drain();
    chk("sat_pos_l", last_l, 32767);
    chk("sat_pos_r", last_r, 32767);
    chk("sat_pos_cnt", int'(clip_count_o), 1);
    strobe(-8192, -8192, -8192, -8192);
    drain();
    chk("sat_neg_l", last_l, -32768);
    chk("sat_neg_r", last_r, -32768);
    chk("sat_neg_cnt", int'(clip_count_o), 2);

    // counter saturation with back-to-back strobes, then clear against a clip
    for (int n = 0; n < 300; n++) strobe(8191, 8191, 8191, 8191);
    drain();
    chk("cnt_sat", int'(clip_count_o), 255);
    strobe(8191, 8191, 8191, 8191);
    idle(1);
    clr_clip_i = 1'b1;
    idle(1);
    clr_clip_i = 1'b0;
    drain();
    chk("cnt_clr_prio", int'(clip_count_o), 0);

    // reset one cycle after a strobe drops the sample
    nv = nvalid;
    strobe(8191, 8191, 8191, 8191);
    do_reset();
    idle(8);
    chk("midrst_no_valid", nvalid, nv);
    chk("midrst_core_l", int'(core_l_o), 0);
    chk("midrst_core_r", int'(core_r_o), 0);
    chk("midrst_cnt", int'(clip_count_o), 0);

    // mute reversal
    volume_i = UNITY_GAIN;
    for (int n = 0; n < 32; n++) strobe(6400, 0, 0, 0);
    mute_i = 1'b1;
    for (int n = 0; n < 22; n++) strobe(6400, 0, 0, 0);
    drain();
    chk("mute_level10", int'(dut.level_q), 10);
    chk("mute_last", last_l, 1100);
    mute_i = 1'b0;
    strobe(6400, 0, 0, 0);
    drain();
    chk("unmute_level11", int'(dut.level_q), 11);
    mute_i = 1'b1;
    for (int n = 0; n < 11; n++) strobe(6400, 0, 0, 0);
    drain();
    chk("muted_level", int'(dut.level_q), 0);
    chk("muted_state", int'(dut.state_q), int'(MUTED));

    // random traffic
    do_reset();
    mute_i = 1'b0;
    for (int b = 0; b < 8; b++) begin
      volume_i = 4'($urandom_range(0, 15));
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 9) == 0) mute_i = ~mute_i;
        strobe(rnd_s(), rnd_s(), rnd_s(), rnd_s());
        idle(int'($urandom_range(0, 2)));
      end
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
